control_pipeline: RTL and testbench

Sequential counterpart to the single-cycle opcode decoder. It consumes the decoded control bundle produced in ID and carries it through the ID/EX, EX/MEM and MEM/WB stage registers of the 5-stage RISC-V core. It detects load-use and ecall hazards, generates stall, flush and forwarding selects, and raises the sticky halt flag when a halting ecall retires. It sits between the decoder and the pipelined datapath; it holds no data values, only control and register indices.

---
 rtl/control_pipeline_pkg.sv | 55 +++++
 rtl/control_pipeline_ctrl_stage_reg.sv | 23 ++
 rtl/control_pipeline.sv | 140 ++++++++++++++
 tb/tb_control_pipeline.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pipeline_pkg.sv
// Shared types and constants for the control pipeline: stage-register layouts,
// forward-select encodings and the forwarding comparator.
package control_pipeline_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // x17 (a7) carries the ecall service number
   localparam logic [4:0] REG_A7 = 5'd17;

   typedef struct packed {
      logic       is_jal;
      logic       is_jalr;
      logic       branch;
      logic       mem_read;
      logic       mem_to_reg;
      logic       mem_write;
      logic       alu_src;
      logic       write_enable;
      logic       pc_to_reg;
      logic       is_ecall;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       halt;
   } idex_t;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       write_enable;
      logic       pc_to_reg;
      logic [4:0] rd;
      logic       halt;
   } exmem_t;

   typedef struct packed {
      logic       mem_to_reg;
      logic       write_enable;
      logic       pc_to_reg;
      logic [4:0] rd;
      logic       halt;
   } memwb_t;

   function automatic logic [1:0] fwd_sel(input logic mem_we, input logic [4:0] mem_rd,
                                          input logic wb_we, input logic [4:0] wb_rd,
                                          input logic [4:0] rs);
      if (mem_we && mem_rd != 5'd0 && mem_rd == rs) return FWD_MEM;
      if (wb_we && wb_rd != 5'd0 && wb_rd == rs) return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/control_pipeline_ctrl_stage_reg.sv
// One pipeline stage register for control bits: async clear, and a
// synchronous bubble input that loads all-zero instead of the next bundle.
module ctrl_stage_reg #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              bubble_i,
   input  logic [DATA_W-1:0] d_i,
   output logic [DATA_W-1:0] q_o
);

   logic [DATA_W-1:0] data_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) data_q <= '0;
      else if (bubble_i) data_q <= '0;
      else data_q <= d_i;
   end

   assign q_o = data_q;

endmodule

// File: rtl/control_pipeline.sv
// Control-only ID/EX, EX/MEM, MEM/WB pipeline with load-use and ecall hazard
// detection, redirect flush, EX operand forwarding and a sticky halt flag.
module control_pipeline
   import control_pipeline_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       id_valid,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic [4:0] id_rd,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   input  logic       id_is_jal,
   input  logic       id_is_jalr,
   input  logic       id_branch,
   input  logic       id_mem_read,
   input  logic       id_mem_to_reg,
   input  logic       id_mem_write,
   input  logic       id_alu_src,
   input  logic       id_write_enable,
   input  logic       id_pc_to_reg,
   input  logic       id_is_ecall,
   input  logic       id_ecall_halt,
   input  logic       ex_redirect,
   output logic       if_id_write,
   output logic       flush_if_id,
   output logic       ex_is_jal,
   output logic       ex_is_jalr,
   output logic       ex_branch,
   output logic       ex_mem_read,
   output logic       ex_mem_to_reg,
   output logic       ex_mem_write,
   output logic       ex_alu_src,
   output logic       ex_write_enable,
   output logic       ex_pc_to_reg,
   output logic       ex_is_ecall,
   output logic [4:0] ex_rd,
   output logic [4:0] ex_rs1,
   output logic [4:0] ex_rs2,
   output logic       mem_mem_read,
   output logic       mem_mem_write,
   output logic       mem_mem_to_reg,
   output logic       mem_write_enable,
   output logic       mem_pc_to_reg,
   output logic [4:0] mem_rd,
   output logic       wb_mem_to_reg,
   output logic       wb_write_enable,
   output logic       wb_pc_to_reg,
   output logic [4:0] wb_rd,
   output logic [1:0] forward_a,
   output logic [1:0] forward_b,
   output logic       is_halted
);

   idex_t  idex_d, idex_q;
   exmem_t exmem_d, exmem_q;
   memwb_t memwb_d, memwb_q;
   logic   halt_pend_q, halted_q;
   logic   load_use, ecall_stall, stall, idex_bubble;

   always_comb begin
      load_use = idex_q.mem_read && idex_q.rd != 5'd0 &&
                 ((id_use_rs1 && id_rs1 == idex_q.rd) || (id_use_rs2 && id_rs2 == idex_q.rd));
      // ecall reads a7 in ID, so any in-flight write to x17 must retire first
      ecall_stall = id_is_ecall &&
                    ((idex_q.write_enable && idex_q.rd == REG_A7) ||
                     (exmem_q.write_enable && exmem_q.rd == REG_A7));
      stall       = (load_use || ecall_stall) && id_valid && !ex_redirect;
      idex_bubble = stall || ex_redirect || !id_valid || halt_pend_q;
   end

   assign if_id_write = !(stall || halt_pend_q);
   assign flush_if_id = ex_redirect;

   always_comb begin
      idex_d = '{is_jal: id_is_jal, is_jalr: id_is_jalr, branch: id_branch,
                 mem_read: id_mem_read, mem_to_reg: id_mem_to_reg, mem_write: id_mem_write,
                 alu_src: id_alu_src, write_enable: id_write_enable, pc_to_reg: id_pc_to_reg,
                 is_ecall: id_is_ecall, rd: id_rd, rs1: id_rs1, rs2: id_rs2,
                 halt: id_is_ecall && id_ecall_halt};
      exmem_d = '{mem_read: idex_q.mem_read, mem_write: idex_q.mem_write,
                  mem_to_reg: idex_q.mem_to_reg, write_enable: idex_q.write_enable,
                  pc_to_reg: idex_q.pc_to_reg, rd: idex_q.rd, halt: idex_q.halt};
      memwb_d = '{mem_to_reg: exmem_q.mem_to_reg, write_enable: exmem_q.write_enable,
                  pc_to_reg: exmem_q.pc_to_reg, rd: exmem_q.rd, halt: exmem_q.halt};
   end

   ctrl_stage_reg #(.DATA_W($bits(idex_t))) u_id_ex (
      .clk(clk), .reset(reset), .bubble_i(idex_bubble), .d_i(idex_d), .q_o(idex_q));
   ctrl_stage_reg #(.DATA_W($bits(exmem_t))) u_ex_mem (
      .clk(clk), .reset(reset), .bubble_i(1'b0), .d_i(exmem_d), .q_o(exmem_q));
   ctrl_stage_reg #(.DATA_W($bits(memwb_t))) u_mem_wb (
      .clk(clk), .reset(reset), .bubble_i(1'b0), .d_i(memwb_d), .q_o(memwb_q));

   // Once a halting ecall is in EX nothing younger may enter; it drains to WB
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         halt_pend_q <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         if (!idex_bubble && idex_d.halt) halt_pend_q <= 1'b1;
         if (memwb_q.halt) halted_q <= 1'b1;
      end
   end

   assign is_halted = halted_q;

   assign forward_a = fwd_sel(exmem_q.write_enable, exmem_q.rd,
                              memwb_q.write_enable, memwb_q.rd, idex_q.rs1);
   assign forward_b = fwd_sel(exmem_q.write_enable, exmem_q.rd,
                              memwb_q.write_enable, memwb_q.rd, idex_q.rs2);

   assign ex_is_jal       = idex_q.is_jal;
   assign ex_is_jalr      = idex_q.is_jalr;
   assign ex_branch       = idex_q.branch;
   assign ex_mem_read     = idex_q.mem_read;
   assign ex_mem_to_reg   = idex_q.mem_to_reg;
   assign ex_mem_write    = idex_q.mem_write;
   assign ex_alu_src      = idex_q.alu_src;
   assign ex_write_enable = idex_q.write_enable;
   assign ex_pc_to_reg    = idex_q.pc_to_reg;
   assign ex_is_ecall     = idex_q.is_ecall;
   assign ex_rd           = idex_q.rd;
   assign ex_rs1          = idex_q.rs1;
   assign ex_rs2          = idex_q.rs2;

   assign mem_mem_read     = exmem_q.mem_read;
   assign mem_mem_write    = exmem_q.mem_write;
   assign mem_mem_to_reg   = exmem_q.mem_to_reg;
   assign mem_write_enable = exmem_q.write_enable;
   assign mem_pc_to_reg    = exmem_q.pc_to_reg;
   assign mem_rd           = exmem_q.rd;

   assign wb_mem_to_reg   = memwb_q.mem_to_reg;
   assign wb_write_enable = memwb_q.write_enable;
   assign wb_pc_to_reg    = memwb_q.pc_to_reg;
   assign wb_rd           = memwb_q.rd;

endmodule

// File: tb/tb_control_pipeline.sv
// Bench for control_pipeline: directed hazard scenarios plus random traffic,
// checked every cycle against an instruction-level reference pipeline.
module tb_control_pipeline;

   // control vector bit positions
   localparam int J = 9, JR = 8, BR = 7, MR = 6, M2R = 5, MW = 4, AS = 3, WE = 2, PC = 1, EC = 0;
   localparam logic [9:0] C_LOAD  = 10'b0001101100;
   localparam logic [9:0] C_ALU   = 10'b0000000100;
   localparam logic [9:0] C_ADDI  = 10'b0000001100;
   localparam logic [9:0] C_ECALL = 10'b0000000001;

   typedef struct packed {
      logic [9:0] c;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       h;
   } ins_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_use_rs1, id_use_rs2, id_ecall_halt, ex_redirect;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic [9:0] id_ctrl;

   logic       if_id_write, flush_if_id;
   logic       ex_is_jal, ex_is_jalr, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write;
   logic       ex_alu_src, ex_write_enable, ex_pc_to_reg, ex_is_ecall;
   logic [4:0] ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
   logic       mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_write_enable, mem_pc_to_reg;
   logic       wb_mem_to_reg, wb_write_enable, wb_pc_to_reg;
   logic [1:0] forward_a, forward_b;
   logic       is_halted;

   int errors = 0;
   int checks = 0;

   ins_t m_ex, m_mem, m_wb;
   logic m_hpend, m_halted, e_stall;

   always #5 clk = ~clk;

   control_pipeline dut (
      .clk(clk), .reset(reset), .id_valid(id_valid),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .id_is_jal(id_ctrl[J]), .id_is_jalr(id_ctrl[JR]), .id_branch(id_ctrl[BR]),
      .id_mem_read(id_ctrl[MR]), .id_mem_to_reg(id_ctrl[M2R]), .id_mem_write(id_ctrl[MW]),
      .id_alu_src(id_ctrl[AS]), .id_write_enable(id_ctrl[WE]), .id_pc_to_reg(id_ctrl[PC]),
      .id_is_ecall(id_ctrl[EC]), .id_ecall_halt(id_ecall_halt), .ex_redirect(ex_redirect),
      .if_id_write(if_id_write), .flush_if_id(flush_if_id),
      .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr), .ex_branch(ex_branch),
      .ex_mem_read(ex_mem_read), .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write),
      .ex_alu_src(ex_alu_src), .ex_write_enable(ex_write_enable), .ex_pc_to_reg(ex_pc_to_reg),
      .ex_is_ecall(ex_is_ecall), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
      .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg),
      .mem_write_enable(mem_write_enable), .mem_pc_to_reg(mem_pc_to_reg), .mem_rd(mem_rd),
      .wb_mem_to_reg(wb_mem_to_reg), .wb_write_enable(wb_write_enable),
      .wb_pc_to_reg(wb_pc_to_reg), .wb_rd(wb_rd),
      .forward_a(forward_a), .forward_b(forward_b), .is_halted(is_halted)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [9:0] c, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic halt);
      id_valid = v; id_ctrl = c; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
      id_use_rs1 = u1; id_use_rs2 = u2; id_ecall_halt = halt;
   endtask

   task automatic model_reset();
      m_ex = '0; m_mem = '0; m_wb = '0; m_hpend = 1'b0; m_halted = 1'b0;
   endtask

   function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
      if (m_mem.c[WE] && m_mem.rd != 0 && m_mem.rd == rs) return 2'b01;
      if (m_wb.c[WE] && m_wb.rd != 0 && m_wb.rd == rs) return 2'b10;
      return 2'b00;
   endfunction

   // Compare every output against the reference for the current state and inputs.
   task automatic check_all(input string tag);
      logic lu, ec;
      lu = m_ex.c[MR] && m_ex.rd != 0 &&
           ((id_use_rs1 && id_rs1 == m_ex.rd) || (id_use_rs2 && id_rs2 == m_ex.rd));
      ec = id_ctrl[EC] && ((m_ex.c[WE] && m_ex.rd == 17) || (m_mem.c[WE] && m_mem.rd == 17));
      e_stall = (lu || ec) && id_valid && !ex_redirect;
      chk({tag, ".if_id_write"}, 32'(if_id_write), 32'(!(e_stall || m_hpend)));
      chk({tag, ".flush"}, 32'(flush_if_id), 32'(ex_redirect));
      chk({tag, ".fwd_a"}, 32'(forward_a), 32'(exp_fwd(m_ex.rs1)));
      chk({tag, ".fwd_b"}, 32'(forward_b), 32'(exp_fwd(m_ex.rs2)));
      chk({tag, ".ex_ctrl"}, 32'({ex_is_jal, ex_is_jalr, ex_branch, ex_mem_read, ex_mem_to_reg,
          ex_mem_write, ex_alu_src, ex_write_enable, ex_pc_to_reg, ex_is_ecall}), 32'(m_ex.c));
      chk({tag, ".ex_idx"}, 32'({ex_rd, ex_rs1, ex_rs2}), 32'({m_ex.rd, m_ex.rs1, m_ex.rs2}));
      chk({tag, ".mem"}, 32'({mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_write_enable,
          mem_pc_to_reg, mem_rd}),
          32'({m_mem.c[MR], m_mem.c[MW], m_mem.c[M2R], m_mem.c[WE], m_mem.c[PC], m_mem.rd}));
      chk({tag, ".wb"}, 32'({wb_mem_to_reg, wb_write_enable, wb_pc_to_reg, wb_rd}),
          32'({m_wb.c[M2R], m_wb.c[WE], m_wb.c[PC], m_wb.rd}));
      chk({tag, ".halted"}, 32'(is_halted), 32'(m_halted));
   endtask

   // Advance the reference by one clock: the instruction in ID is accepted
   // unless stalled, redirected, invalid or blocked by a pending halt.
   task automatic model_edge();
      ins_t nx;
      nx = '{c: id_ctrl, rd: id_rd, rs1: id_rs1, rs2: id_rs2, h: id_ctrl[EC] & id_ecall_halt};
      if (e_stall || ex_redirect || !id_valid || m_hpend) nx = '0;
      if (m_wb.h) m_halted = 1'b1;
      if (nx.h) m_hpend = 1'b1;
      m_wb = m_mem; m_mem = m_ex; m_ex = nx;
   endtask

   task automatic cyc(input string tag);
      #1;
      check_all(tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; ex_redirect = 1'b0;
      set_id(1'b0, '0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      model_reset();
      @(negedge clk); @(negedge clk);
      #1;
      chk("reset.if_id_write", 32'(if_id_write), 32'd1);
      chk("reset.flush", 32'(flush_if_id), 32'd0);
      chk("reset.fwd", 32'({forward_a, forward_b}), 32'd0);
      check_all("reset");
      reset = 1'b0;

      // load x5 ; add x6,x5,x7
      set_id(1'b1, C_LOAD, 5, 1, 0, 1'b1, 1'b0, 1'b0); cyc("lu.load");
      set_id(1'b1, C_ALU, 6, 5, 7, 1'b1, 1'b1, 1'b0);
      #1; chk("lu.stall", 32'(if_id_write), 32'd0);
      cyc("lu.add_id");
      #1; chk("lu.bubble", 32'({ex_mem_read, ex_write_enable, ex_rd}), 32'd0);
      chk("lu.release", 32'(if_id_write), 32'd1);
      cyc("lu.add_held");
      set_id(1'b0, '0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      #1; chk("lu.fwd_a", 32'(forward_a), 32'd2);
      cyc("lu.add_ex");
      cyc("lu.drain");

      // add x3 ; sub x4,x3,x3 back-to-back, then with a nop between
      set_id(1'b1, C_ALU, 3, 1, 2, 1'b1, 1'b1, 1'b0); cyc("fw.add");
      set_id(1'b1, C_ALU, 4, 3, 3, 1'b1, 1'b1, 1'b0); cyc("fw.sub");
      set_id(1'b0, '0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      #1; chk("fw.mem", 32'({forward_a, forward_b}), 32'b0101);
      cyc("fw.sub_ex");
      set_id(1'b1, C_ALU, 3, 1, 2, 1'b1, 1'b1, 1'b0); cyc("fw2.add");
      set_id(1'b1, C_ADDI, 0, 0, 0, 1'b0, 1'b0, 1'b0); cyc("fw2.nop");
      set_id(1'b1, C_ALU, 4, 3, 3, 1'b1, 1'b1, 1'b0); cyc("fw2.sub");
      set_id(1'b0, '0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      #1; chk("fw2.wb", 32'({forward_a, forward_b}), 32'b1010);
      cyc("fw2.sub_ex");

      // writes to x0 never forward or stall
      set_id(1'b1, C_LOAD, 0, 1, 0, 1'b1, 1'b0, 1'b0); cyc("x0.load");
      set_id(1'b1, C_ALU, 7, 0, 0, 1'b1, 1'b1, 1'b0);
      #1; chk("x0.nostall", 32'(if_id_write), 32'd1);
      cyc("x0.use");
      set_id(1'b0, '0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      #1; chk("x0.fwd", 32'({forward_a, forward_b}), 32'd0);
      cyc("x0.ex");

      // redirect beats load-use
      set_id(1'b1, C_LOAD, 5, 1, 0, 1'b1, 1'b0, 1'b0); cyc("rd.load");
      set_id(1'b1, C_ALU, 6, 5, 5, 1'b1, 1'b1, 1'b0); ex_redirect = 1'b1;
      #1; chk("rd.flush_ifw", 32'({flush_if_id, if_id_write}), 32'b11);
      cyc("rd.redirect");
      ex_redirect = 1'b0; set_id(1'b0, '0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      #1; chk("rd.bubble", 32'({ex_write_enable, ex_rd, ex_rs1}), 32'd0);
      cyc("rd.after");

      // random traffic without halting ecalls
      for (int i = 0; i < 400; i++) begin
         logic [9:0] c;
         c = 10'($urandom) & 10'b1111111110;
         c[EC] = ($urandom_range(0, 7) == 0);
         set_id($urandom_range(0, 3) != 0, c, 5'($urandom_range(0, 7)),
                5'(c[EC] ? 17 : $urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                1'($urandom), 1'($urandom), 1'b0);
         if (c[EC]) id_use_rs1 = 1'b1;
         ex_redirect = ($urandom_range(0, 7) == 0);
         cyc("rand");
      end
      ex_redirect = 1'b0;

      // asynchronous reset while a load sits in MEM
      set_id(1'b1, C_LOAD, 9, 1, 0, 1'b1, 1'b0, 1'b0); cyc("rst.load");
      set_id(1'b1, C_ALU, 8, 2, 3, 1'b1, 1'b1, 1'b0); cyc("rst.next");
      #2; reset = 1'b1; #1;
      model_reset();
      chk("rst.mem_clear", 32'({mem_mem_read, mem_rd}), 32'd0);
      check_all("rst.async");
      @(negedge clk); reset = 1'b0;

      // addi x17,x0,10 ; ecall (halting)
      set_id(1'b1, C_ADDI, 17, 0, 0, 1'b0, 1'b0, 1'b0); cyc("ec.addi");
      set_id(1'b1, C_ECALL, 0, 17, 0, 1'b1, 1'b0, 1'b1);
      #1; chk("ec.stall1", 32'(if_id_write), 32'd0);
      cyc("ec.s1");
      #1; chk("ec.stall2", 32'(if_id_write), 32'd0);
      cyc("ec.s2");
      #1; chk("ec.accept", 32'(if_id_write), 32'd1);
      cyc("ec.accept");
      set_id(1'b0, '0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      #1; chk("ec.ex", 32'({ex_is_ecall, is_halted, if_id_write}), 32'b100);
      cyc("ec.e1");
      #1; chk("ec.edge1", 32'(is_halted), 32'd0);
      cyc("ec.e2");
      #1; chk("ec.edge2", 32'(is_halted), 32'd0);
      cyc("ec.e3");
      #1; chk("ec.edge3", 32'(is_halted), 32'd1);
      set_id(1'b1, C_ALU, 4, 1, 2, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cyc("ec.hold");
      #1; chk("ec.held", 32'({is_halted, if_id_write}), 32'b10);

      #2; reset = 1'b1; #1;
      model_reset();
      chk("ec.rst_halt", 32'(is_halted), 32'd0);
      check_all("ec.rst");
      @(negedge clk); reset = 1'b0;
      set_id(1'b0, '0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      cyc("end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
